// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped 8-byte-line instruction cache responder with tagged miss fill
module icache_responder #(
  parameter int NUM_LINES = 32,
  parameter int IDX_BITS  = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] proc2Imem_addr,
  input  logic        access_memory,
  output logic [63:0] Imem2proc_data,
  output logic        IR_valid,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag
);

  localparam int TAG_W = 64 - IDX_BITS - 3;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t             r_state;
  logic [3:0]         r_pend_tag;
  logic [60:0]        r_miss_addr;   // fetch address bits [63:3]
  logic               r_valid [NUM_LINES];
  logic [TAG_W-1:0]   r_tag   [NUM_LINES];
  logic [63:0]        r_data  [NUM_LINES];

  logic [IDX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [IDX_BITS-1:0] w_fill_idx;
  logic [TAG_W-1:0]    w_fill_tag;
  logic                w_hit;
  logic                w_tag_match;
  logic                w_fill;
  logic                w_fwd;
  logic                w_issue;
  logic                w_unused_ok;

  // Byte offset within the line never selects anything; the whole line is returned.
  assign w_unused_ok = ^proc2Imem_addr[2:0];

  assign w_idx      = proc2Imem_addr[IDX_BITS+2:3];
  assign w_tag      = proc2Imem_addr[63:IDX_BITS+3];
  assign w_fill_idx = r_miss_addr[IDX_BITS-1:0];
  assign w_fill_tag = r_miss_addr[60:IDX_BITS];

  // Lookup, fill detection and bus-issue decode; tag 0 is reserved for "no data" and never matches.
  always_comb begin
    w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    w_tag_match = (r_state == S_WAIT) && (mem2proc_tag != 4'd0) && (mem2proc_tag == r_pend_tag);
    w_fill      = !reset && w_tag_match;
    w_fwd       = w_tag_match && (proc2Imem_addr[63:3] == r_miss_addr);
    w_issue     = (r_state == S_REQ) && !access_memory;
  end

  // Fetch response: forward returning fill data first, otherwise serve a hit; everything is quiet in reset.
  always_comb begin
    IR_valid       = 1'b0;
    Imem2proc_data = 64'h0;
    if (!reset) begin
      if (w_fwd) begin
        IR_valid       = 1'b1;
        Imem2proc_data = mem2proc_data;
      end else if (w_hit) begin
        IR_valid       = 1'b1;
        Imem2proc_data = r_data[w_idx];
      end
    end
  end

  // Bus request: a line load is only presented while requesting and the data side leaves the bus free.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = 64'h0;
    if (!reset && w_issue) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = {r_miss_addr, 3'b000};
    end
  end

  // Miss FSM and line valid bits; one outstanding miss, a fill always overwrites its line.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pend_tag  <= 4'd0;
      r_miss_addr <= 61'd0;
      for (int i = 0; i < NUM_LINES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_hit) begin
            r_miss_addr <= proc2Imem_addr[63:3];
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_issue && (mem2proc_response != 4'd0)) begin
            r_pend_tag <= mem2proc_response;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_pend_tag          <= 4'd0;
            r_state             <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line tag and data storage written on the matching fill cycle; contents are qualified by the valid bits.
  always_ff @(posedge clock) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem2proc_data;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - table and sequence driven scoreboard bench for icache_responder
module tb_icache_responder;

  logic        clock;
  logic        reset;
  logic [63:0] proc2Imem_addr;
  logic        access_memory;
  logic [63:0] Imem2proc_data;
  logic        IR_valid;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  icache_responder #(.NUM_LINES(32), .IDX_BITS(5)) dut (
    .clock             (clock),
    .reset             (reset),
    .proc2Imem_addr    (proc2Imem_addr),
    .access_memory     (access_memory),
    .Imem2proc_data    (Imem2proc_data),
    .IR_valid          (IR_valid),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;

  typedef struct {
    logic        rst;
    logic [63:0] addr;
    logic        am;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] mdata;
    logic        e_ir;
    logic [63:0] e_data;
    logic [1:0]  e_cmd;
    logic [63:0] e_paddr;
  } vec_t;

  typedef struct {
    logic        e_ir;
    logic [63:0] e_data;
    logic [1:0]  e_cmd;
    logic [63:0] e_paddr;
  } exp_t;

  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_step = 0;
  string cur_label;

  localparam logic [63:0] D_A = 64'h1111_1111_2222_2222;
  localparam logic [63:0] D_B = 64'hB0B0_0100_CAFE_0001;
  localparam logic [63:0] D_C = 64'h0000_0000_0000_0C0C;
  localparam logic [63:0] D_D = 64'h3333_2020_4444_0003;
  localparam logic [63:0] D_E = 64'h1818_1818_5555_0004;
  localparam logic [63:0] D_F = 64'hDEAD_BEEF_0000_0002;
  localparam logic [63:0] D_G = 64'h4040_4040_6666_0005;

  task automatic check_field(input string fld, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s step %0d %s: got %h expected %h", cur_label, n_step, fld, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare mid-cycle, advance past the edge.
  task automatic step(input logic rst, input logic [63:0] addr, input logic am,
                      input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] mdata,
                      input logic e_ir, input logic [63:0] e_data,
                      input logic [1:0] e_cmd, input logic [63:0] e_paddr);
    exp_t e;
    exp_t got;
    reset             = rst;
    proc2Imem_addr    = addr;
    access_memory     = am;
    mem2proc_response = resp;
    mem2proc_tag      = tag;
    mem2proc_data     = mdata;
    e.e_ir    = e_ir;
    e.e_data  = e_data;
    e.e_cmd   = e_cmd;
    e.e_paddr = e_paddr;
    sb.push_back(e);
    @(negedge clock);
    got = sb.pop_front();
    check_field("IR_valid", {63'd0, IR_valid}, {63'd0, got.e_ir});
    check_field("Imem2proc_data", Imem2proc_data, got.e_data);
    check_field("proc2mem_command", {62'd0, proc2mem_command}, {62'd0, got.e_cmd});
    check_field("proc2mem_addr", proc2mem_addr, got.e_paddr);
    n_step++;
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input vec_t v);
    step(v.rst, v.addr, v.am, v.resp, v.tag, v.mdata, v.e_ir, v.e_data, v.e_cmd, v.e_paddr);
  endtask

  vec_t cold[8];

  initial begin
    reset = 1'b1;
    proc2Imem_addr = 64'h0;
    access_memory = 1'b0;
    mem2proc_response = 4'd0;
    mem2proc_tag = 4'd0;
    mem2proc_data = 64'h0;

    //            rst   addr    am    resp  tag   mdata  ir    data  cmd   paddr
    cold[0] = '{1'b1, 64'h0, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, NONE, 64'h0};
    cold[1] = '{1'b0, 64'h0, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, NONE, 64'h0};
    cold[2] = '{1'b0, 64'h0, 1'b0, 4'd1, 4'd0, 64'h0, 1'b0, 64'h0, LOAD, 64'h0};
    cold[3] = '{1'b0, 64'h0, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, NONE, 64'h0};
    cold[4] = '{1'b0, 64'h0, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, NONE, 64'h0};
    cold[5] = '{1'b0, 64'h0, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, NONE, 64'h0};
    cold[6] = '{1'b0, 64'h0, 1'b0, 4'd0, 4'd1, D_A,   1'b1, D_A,   NONE, 64'h0};
    cold[7] = '{1'b0, 64'h4, 1'b0, 4'd0, 4'd0, 64'h0, 1'b1, D_A,   NONE, 64'h0};

    @(posedge clock);
    #1;

    cur_label = "cold_miss";
    for (int i = 0; i < 8; i++) begin
      apply(cold[i]);
    end

    // Bus conflict on 0x100, which also evicts 0x0 from index 0.
    cur_label = "bus_conflict";
    step(1'b0, 64'h100, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, NONE, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 64'h100, 1'b1, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, NONE, 64'h0);
    end
    step(1'b0, 64'h100, 1'b0, 4'd1, 4'd0, 64'h0, 1'b0, 64'h0, LOAD, 64'h100);
    step(1'b0, 64'h100, 1'b0, 4'd0, 4'd1, D_B,   1'b1, D_B,   NONE, 64'h0);

    cur_label = "conflict_evict";
    step(1'b0, 64'h100, 1'b0, 4'd0, 4'd0, 64'h0, 1'b1, D_B,   NONE, 64'h0);
    step(1'b0, 64'h0,   1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, NONE, 64'h0);
    step(1'b0, 64'h0,   1'b0, 4'd2, 4'd0, 64'h0, 1'b0, 64'h0, LOAD, 64'h0);
    step(1'b0, 64'h0,   1'b0, 4'd0, 4'd2, D_C,   1'b1, D_C,   NONE, 64'h0);

    // Rejected twice, accepted with tag 3; a foreign tag in WAIT is ignored.
    cur_label = "rejection";
    step(1'b0, 64'h20, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, NONE, 64'h0);
    step(1'b0, 64'h20, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, LOAD, 64'h20);
    step(1'b0, 64'h20, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, LOAD, 64'h20);
    step(1'b0, 64'h20, 1'b0, 4'd3, 4'd0, 64'h0, 1'b0, 64'h0, LOAD, 64'h20);
    step(1'b0, 64'h20, 1'b0, 4'd0, 4'd1, 64'h5A5A, 1'b0, 64'h0, NONE, 64'h0);
    step(1'b0, 64'h20, 1'b0, 4'd0, 4'd3, D_D,   1'b1, D_D,   NONE, 64'h0);
    step(1'b0, 64'h24, 1'b0, 4'd0, 4'd0, 64'h0, 1'b1, D_D,   NONE, 64'h0);

    // Redirect to cached 0x0 during WAIT; the 0x18 fill still lands.
    cur_label = "redirect";
    step(1'b0, 64'h18, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, NONE, 64'h0);
    step(1'b0, 64'h18, 1'b0, 4'd4, 4'd0, 64'h0, 1'b0, 64'h0, LOAD, 64'h18);
    step(1'b0, 64'h0,  1'b0, 4'd0, 4'd0, 64'h0, 1'b1, D_C,   NONE, 64'h0);
    step(1'b0, 64'h0,  1'b0, 4'd0, 4'd4, D_E,   1'b1, D_C,   NONE, 64'h0);
    step(1'b0, 64'h18, 1'b0, 4'd0, 4'd0, 64'h0, 1'b1, D_E,   NONE, 64'h0);
    step(1'b0, 64'h1C, 1'b0, 4'd0, 4'd0, 64'h0, 1'b1, D_E,   NONE, 64'h0);

    // Reset while waiting on tag 2; the late tag must not write the line.
    cur_label = "reset_mid_miss";
    step(1'b0, 64'h40, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, NONE, 64'h0);
    step(1'b0, 64'h40, 1'b0, 4'd2, 4'd0, 64'h0, 1'b0, 64'h0, LOAD, 64'h40);
    step(1'b0, 64'h40, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, NONE, 64'h0);
    step(1'b1, 64'h40, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, NONE, 64'h0);
    step(1'b0, 64'h40, 1'b0, 4'd0, 4'd2, D_F,   1'b0, 64'h0, NONE, 64'h0);
    step(1'b0, 64'h40, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0, 64'h0, LOAD, 64'h40);
    step(1'b0, 64'h40, 1'b0, 4'd5, 4'd0, 64'h0, 1'b0, 64'h0, LOAD, 64'h40);
    step(1'b0, 64'h40, 1'b0, 4'd0, 4'd5, D_G,   1'b1, D_G,   NONE, 64'h0);
    step(1'b0, 64'h40, 1'b0, 4'd0, 4'd0, 64'h0, 1'b1, D_G,   NONE, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-side responder for the 2-wide fetch stage: answers `proc2Imem_addr` with `Imem2proc_data` and `IR_valid`.
- Direct-mapped, 8-byte-line instruction cache.
- On a miss it issues a tagged BUS_LOAD to main memory, arbitrates against data-side traffic via `access_memory`, and fills the line when the tagged response returns.
- Sits between `if_stage` and the shared memory bus.

Parameters:
- NUM_LINES, 32, number of cache lines (power of two).
- IDX_BITS, 5, log2(NUM_LINES).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- proc2Imem_addr  input  64  fetch address from if_stage; bits [2:0] ignored.
- access_memory  input  1  data side owns the bus this cycle; no icache command may be issued.
- Imem2proc_data  output  64  8-byte line for the fetch address.
- IR_valid  output  1  Imem2proc_data is valid for proc2Imem_addr this cycle.
- proc2mem_command  output  2  0=BUS_NONE, 1=BUS_LOAD.
- proc2mem_addr  output  64  line-aligned miss address, {miss_addr[63:3],3'b0}.
- mem2proc_response  input  4  nonzero = request accepted, value is its tag; 0 = rejected.
- mem2proc_data  input  64  returning line data.
- mem2proc_tag  input  4  tag of the returning data; 0 = no data this cycle.

Behaviour:
- Address split:
  - index = addr[IDX_BITS+2:3]
  - tag = addr[63:IDX_BITS+3]
- Per-line storage: valid bit, tag, 64-bit data.
- Hit (combinational, any state): valid[index] && tag match -> IR_valid=1, Imem2proc_data=line data, same cycle.
- Miss:
  - IR_valid=0.
  - Imem2proc_data=64'h0.
- Fill forwarding:
  - Applies in the WAIT cycle where mem2proc_tag==pend_tag and proc2Imem_addr[63:3]==miss_addr[63:3].
  - Drive IR_valid=1 and Imem2proc_data=mem2proc_data.
- Reset (synchronous):
  - All valid bits clear; state=IDLE; pend_tag=0; miss_addr=0.
  - While reset=1: IR_valid=0, Imem2proc_data=0, proc2mem_command=BUS_NONE, proc2mem_addr=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Miss -> latch miss_addr=proc2Imem_addr, go to REQ.
  - Hit -> stay.
  - No bus command in IDLE.
- REQ:
  - access_memory=1 -> command BUS_NONE, stay REQ.
  - access_memory=0 -> command BUS_LOAD, proc2mem_addr=aligned miss_addr.
  - Nonzero mem2proc_response that same cycle -> latch pend_tag, go to WAIT.
  - Response 0 -> stay REQ and retry next cycle.
- WAIT:
  - Command BUS_NONE.
  - mem2proc_tag==pend_tag (nonzero) -> write valid/tag/data at miss index, clear pend_tag, go to IDLE.
  - Other tags ignored.
- Minimum miss-to-IR_valid latency: 2 cycles + memory latency (IDLE detect, REQ accept, data on tag cycle via forwarding).
- Fetch address changes during REQ/WAIT (e.g. mispredict redirect):
  - The outstanding fill is not cancelled and still writes the line.
  - The new address is served only on a hit.
  - A miss on the new address is detected in IDLE after the fill completes.
- Hit-under-miss is permitted. Only one outstanding miss at a time.
- A fill always overwrites the indexed line, regardless of prior valid/tag.
- Reset during REQ/WAIT: state returns to IDLE. A later returning pend_tag is ignored, and no line is written.
- Tag 0 on mem2proc_tag never matches.

Test Plan:
- Cold miss: reset 1 cycle, addr=0x0. Memory accepts with response=1 on the first REQ cycle and returns tag=1, data=64'h1111_1111_2222_2222 four cycles later.
  -> BUS_LOAD addr 0x0 for exactly one cycle; IR_valid=1 on the tag cycle with that data; addr=0x4 next cycle hits with the same data.
- Bus conflict: miss at 0x100 with access_memory=1 for 3 cycles.
  -> proc2mem_command=BUS_NONE for those 3 cycles, then BUS_LOAD 0x100 on the first cycle access_memory=0.
- Rejection: miss at 0x20, response=0 for 2 cycles then 3.
  -> BUS_LOAD 0x20 held 3 cycles; fill accepted only on tag=3.
- Redirect mid-miss: miss at 0x18, then fetch address switches to 0x0 (cached) during WAIT.
  -> IR_valid=1 immediately for 0x0; fill for 0x18 still writes; a later fetch of 0x18 hits with no new BUS_LOAD.
- Conflict eviction: fill 0x0, then fetch 0x100 (same index, NUM_LINES=32).
  -> Miss, refill; a subsequent 0x0 fetch misses again.
- Reset mid-miss: reset asserted during WAIT with pend_tag=2, then tag=2 returns.
  -> No line written; IR_valid=0 for that address; a new BUS_LOAD is issued.
